lshift_reg: RTL and testbench
=============================

// Module: lshift_reg
// PURPOSE
//   Parameterised left-shift / rotate register with synchronous parallel load.
//   Holds a WIDTH-bit word on op and moves it one bit toward the MSB every clock
//   while no load is requested.
//   Used as a pattern/sequence generator and walking-bit source in datapath
//   experiments; a single clock domain with no handshaking.
// PARAMETERS
//   WIDTH   8   register width in bits (>=2)
//   ROTATE  1   1: circular rotate-left (MSB re-enters at bit 0); 0: logical shift-left, bit 0 filled with 0
// PORTS
//   clk       in   1      clock; all state updates on rising edge
//   rstn      in   1      synchronous reset, ACTIVE-HIGH (rstn=1 clears register at next rising edge)
//   load_en   in   1      parallel-load request, active-high
//   load_val  in   WIDTH  value captured when load_en=1
//   op        out  WIDTH  current register contents (registered, no combinational path from inputs)
// BEHAVIOUR
//   - Single register r[WIDTH-1:0]; op = r at all times.
//   - Per rising edge of clk, priority order:
//       1. rstn=1                : r <= 0 (load_en, load_val ignored)
//       2. rstn=0, load_en=1     : r <= load_val
//       3. rstn=0, load_en=0     : ROTATE=1 -> r <= {r[WIDTH-2:0], r[WIDTH-1]}
//                                  ROTATE=0 -> r <= {r[WIDTH-2:0], 1'b0}
//   - Reset value of op: all zeros. Reset is synchronous; asserting rstn between
//     edges has no effect until the next rising edge. X on op before first edge is permitted.
//   - Latency: load visible on op one cycle after the edge that samples load_en=1;
//     each shift step takes exactly one clock.
//   - Holding load_en=1 reloads load_val every cycle (no shifting).
//   - Reset asserted mid-sequence discards contents immediately at that edge;
//     after release, register shifts zeros (stays 0) until a load occurs.
//   - ROTATE=1: pattern period divides WIDTH; all-0 and all-1 words are fixed points.
//   - ROTATE=0: any loaded value reaches 0 after at most WIDTH shifts, then stays 0.
//   - No overflow/status outputs; bits shifted out of MSB in ROTATE=0 mode are discarded.
//   - load_val width mismatch is not tolerated: port is exactly WIDTH bits.
// TESTING
//   (WIDTH=8, ROTATE=1 unless noted; 20 ns clock)
//   1. rstn=1 for 5 cycles, load_en=0 -> op=8'h00 from first edge onward.
//   2. Release rstn, load_en=1, load_val=8'h55 for 5 cycles -> op=8'h55 after first edge, stays 8'h55.
//   3. Then load_en=0 -> op alternates 8'hAA, 8'h55, 8'hAA ... each cycle for 100 cycles.
//   4. Load 8'h81, shift -> op sequence 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81.
//   5. ROTATE=0: load 8'h81, shift -> 8'h02, 8'h04, ... 8'h80, 8'h00, then holds 8'h00.
//   6. During shifting assert rstn and load_en=1 (load_val=8'hFF) together -> op=8'h00
//      (reset wins); release rstn with load_en=1 -> op=8'hFF next cycle.

Source files
------------

// File: rtl/lshift_reg.sv
// lshift_reg: left-shift or rotate-left register with synchronous parallel load
module lshift_reg #(
    parameter int WIDTH  = 8,
    parameter bit ROTATE = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] op
);
    logic [WIDTH-1:0] r_q, r_d;
    // rstn is active-high despite its name; load takes priority over shifting
    always_comb r_d = load_en ? load_val : {r_q[WIDTH-2:0], ROTATE ? r_q[WIDTH-1] : 1'b0};
    always_ff @(posedge clk)
        r_q <= rstn ? '0 : r_d;
    assign op = r_q;
endmodule

// File: tb/tb_lshift_reg.sv
// tb_lshift_reg: directed vectors for the rotate and logical-shift variants side by side
module tb_lshift_reg;
    logic       clk = 1'b0;
    logic       rstn, load_en;
    logic [7:0] load_val;
    logic [7:0] op_rot, op_shl;
    int         vectors = 0;
    int         miscompares = 0;

    lshift_reg #(.WIDTH(8), .ROTATE(1'b1)) u_rot (
        .clk(clk), .rstn(rstn), .load_en(load_en), .load_val(load_val), .op(op_rot));
    lshift_reg #(.WIDTH(8), .ROTATE(1'b0)) u_shl (
        .clk(clk), .rstn(rstn), .load_en(load_en), .load_val(load_val), .op(op_shl));

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rot_seq [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    logic [7:0] shl_seq [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    logic [7:0] shl_55  [8] = '{8'hAA, 8'h54, 8'hA8, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};

    initial begin
        rstn = 1'b1; load_en = 1'b0; load_val = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_rot", op_rot, 8'h00);
            chk("reset_shl", op_shl, 8'h00);
        end
        rstn = 1'b0; load_en = 1'b1; load_val = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_load_rot", op_rot, 8'h55);
            chk("hold_load_shl", op_shl, 8'h55);
        end
        load_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("alt_rot", op_rot, (i % 2 == 0) ? 8'hAA : 8'h55);
            chk("shl_55", op_shl, (i < 8) ? shl_55[i] : 8'h00);
        end
        load_en = 1'b1; load_val = 8'h81;
        tick();
        chk("load81_rot", op_rot, 8'h81);
        chk("load81_shl", op_shl, 8'h81);
        load_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("walk_rot", op_rot, rot_seq[i]);
            chk("walk_shl", op_shl, shl_seq[i]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("period_rot", op_rot, rot_seq[i]);
            chk("drain_shl", op_shl, 8'h00);
        end
        load_en = 1'b1; load_val = 8'h81;
        tick();
        load_en = 1'b0;
        tick();
        chk("pre_rst_rot", op_rot, 8'h03);
        chk("pre_rst_shl", op_shl, 8'h02);
        rstn = 1'b1; load_en = 1'b1; load_val = 8'hFF;
        #5;
        chk("async_none_rot", op_rot, 8'h03);
        chk("async_none_shl", op_shl, 8'h02);
        tick();
        chk("rst_wins_rot", op_rot, 8'h00);
        chk("rst_wins_shl", op_shl, 8'h00);
        rstn = 1'b0;
        tick();
        chk("reload_rot", op_rot, 8'hFF);
        chk("reload_shl", op_shl, 8'hFF);
        load_en = 1'b0;
        tick();
        chk("ones_fixed_rot", op_rot, 8'hFF);
        chk("ones_shl", op_shl, 8'hFE);
        tick();
        chk("ones_fixed_rot2", op_rot, 8'hFF);
        chk("ones_shl2", op_shl, 8'hFC);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("zero_after_rst_rot", op_rot, 8'h00);
            chk("zero_after_rst_shl", op_shl, 8'h00);
        end
        load_en = 1'b1; load_val = 8'hB4;
        tick();
        load_en = 1'b0;
        tick();
        chk("b4_rot", op_rot, 8'h69);
        chk("b4_shl", op_shl, 8'h68);
        tick();
        chk("b4_rot2", op_rot, 8'hD2);
        chk("b4_shl2", op_shl, 8'hD0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
